bcd_ex3_seq_ctrl: RTL and testbench

//   Sequencer that converts a packed multi-digit BCD word to excess-3, one digit per clock.

---
 rtl/bcd_ex3_seq_ctrl_pkg.sv | 7 +
 rtl/bcd_ex3_seq_ctrl_if.sv | 16 +
 rtl/bcd_ex3_seq_ctrl_digit.sv | 11 +
 rtl/bcd_ex3_seq_ctrl.sv | 83 ++++++++
 tb/tb_bcd_ex3_seq_ctrl.sv | 189 ++++++++++++++++++
 5 files changed

// File: rtl/bcd_ex3_seq_ctrl_pkg.sv
// bcd_ex3_pkg: shared FSM state type and BCD/excess-3 constants for the sequencer.
package bcd_ex3_pkg;
    typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;
    localparam logic [3:0] BCD_MAX     = 4'd9;
    localparam logic [3:0] EX3_OFFSET  = 4'd3;
    localparam logic [3:0] EX3_INVALID = 4'h0;
endpackage

// File: rtl/bcd_ex3_seq_ctrl_if.sv
// bcd_ex3_seq_ctrl_if: producer/consumer handshake bundle; master = environment, slave = sequencer.
interface bcd_ex3_seq_ctrl_if #(parameter int NDIG = 4);
    logic                in_valid;
    logic                in_ready;
    logic [4*NDIG-1:0]   in_bcd;
    logic                out_valid;
    logic                out_ready;
    logic [4*NDIG-1:0]   out_ex3;
    logic                out_err;
    logic [NDIG-1:0]     out_err_mask;
    logic                busy;
    modport master (output in_valid, in_bcd, out_ready,
                    input  in_ready, out_valid, out_ex3, out_err, out_err_mask, busy);
    modport slave  (input  in_valid, in_bcd, out_ready,
                    output in_ready, out_valid, out_ex3, out_err, out_err_mask, busy);
endinterface

// File: rtl/bcd_ex3_seq_ctrl_digit.sv
// bcd_ex3_digit: combinational single-digit BCD to excess-3 converter with invalid flag.
module bcd_ex3_digit
    import bcd_ex3_pkg::*;
(
    input  logic [3:0] d,
    output logic [3:0] ex3,
    output logic       invalid
);
    assign invalid = d > BCD_MAX;
    assign ex3     = invalid ? EX3_INVALID : d + EX3_OFFSET;
endmodule

// File: rtl/bcd_ex3_seq_ctrl.sv
// bcd_ex3_seq_ctrl: digit-serial BCD to excess-3 word converter; BCD_EX3_ERRCNT_EN adds a saturating error-word counter.
module bcd_ex3_seq_ctrl
    import bcd_ex3_pkg::*;
#(
    parameter int NDIG = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    bcd_ex3_seq_ctrl_if.slave    bus
`ifdef BCD_EX3_ERRCNT_EN
    ,
    output logic [7:0]           err_count
`endif
);
    localparam int W  = 4 * NDIG;
    localparam int IW = NDIG > 1 ? $clog2(NDIG) : 1;

    state_t          state, state_n;
    logic [IW-1:0]   idx;
    logic [W-1:0]    sh, res, res_n;
    logic [NDIG-1:0] mask, mask_n;
    logic [3:0]      dig_ex3;
    logic            dig_inv;
    logic            accept, deliver, last;

    bcd_ex3_digit u_digit (.d(sh[3:0]), .ex3(dig_ex3), .invalid(dig_inv));

    assign accept  = state == IDLE && bus.in_valid;
    assign deliver = state == DONE && bus.out_ready;
    assign last    = idx == IW'(NDIG - 1);
    // converted digits enter at the top so digit 0 lands in bits [3:0] after NDIG shifts
    assign res_n   = W'({dig_ex3, res} >> 4);
    assign mask_n  = NDIG'({dig_inv, mask} >> 1);

    always_comb begin
        state_n = state;
        state_n = accept                  ? CONV :
                  (state == CONV && last) ? DONE :
                  deliver                 ? IDLE : state;
    end

    always_ff @(posedge clk) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_n;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx  <= '0;
            sh   <= '0;
            res  <= '0;
            mask <= '0;
        end else if (accept) begin
            idx  <= '0;
            sh   <= bus.in_bcd;
            res  <= '0;
            mask <= '0;
        end else if (state == CONV) begin
            idx  <= last ? '0 : idx + IW'(1);
            sh   <= sh >> 4;
            res  <= res_n;
            mask <= mask_n;
        end
    end

    assign bus.in_ready     = state == IDLE;
    assign bus.out_valid    = state == DONE;
    assign bus.busy         = state != IDLE;
    assign bus.out_ex3      = res;
    assign bus.out_err_mask = mask;
    assign bus.out_err      = |mask;

`ifdef BCD_EX3_ERRCNT_EN
    always_ff @(posedge clk) begin
        if (rst)
            err_count <= '0;
        else if (deliver && bus.out_err && err_count != 8'hFF)
            err_count <= err_count + 8'd1;
    end
`endif
endmodule

// File: tb/tb_bcd_ex3_seq_ctrl.sv
// tb_bcd_ex3_seq_ctrl: table-driven scoreboard bench for the BCD to excess-3 sequencer (NDIG=4).
module tb_bcd_ex3_seq_ctrl;
    typedef struct {logic [15:0] ex3; logic [3:0] mask;} exp_t;
    typedef struct {logic [15:0] bcd; logic [15:0] ex3; logic [3:0] mask;} vec_t;

    logic clk = 0;
    logic rst = 1;
    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    vec_t tbl[7];
`ifdef BCD_EX3_ERRCNT_EN
    logic [7:0] err_count;
`endif

    bcd_ex3_seq_ctrl_if #(.NDIG(4)) bus();

    bcd_ex3_seq_ctrl #(.NDIG(4)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
`ifdef BCD_EX3_ERRCNT_EN
        ,
        .err_count(err_count)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // reference conversion built digit by digit
    function automatic exp_t model(input logic [15:0] w);
        exp_t r;
        for (int i = 0; i < 4; i++) begin
            logic [3:0] d;
            d = w[4*i +: 4];
            r.mask[i]       = d > 4'd9;
            r.ex3[4*i +: 4] = d > 4'd9 ? 4'h0 : d + 4'd3;
        end
        return r;
    endfunction

    task automatic send(input logic [15:0] w, input logic [15:0] e, input logic [3:0] m);
        int n = 0;
        bus.in_valid = 1;
        bus.in_bcd   = w;
        while (!bus.in_ready && n < 20) begin tick; n++; end
        check("in_ready_before_accept", bus.in_ready, 1);
        tick;
        bus.in_valid = 0;
        bus.in_bcd   = 16'($urandom);
        sb.push_back('{e, m});
    endtask

    task automatic recv(input int hold);
        int   n = 0;
        exp_t x;
        while (!bus.out_valid && n < 20) begin tick; n++; end
        check("latency", n, 4);
        if (sb.size() == 0) begin
            check("scoreboard_empty", 0, 1);
            return;
        end
        x = sb.pop_front();
        check("out_ex3", bus.out_ex3, x.ex3);
        check("out_err_mask", bus.out_err_mask, x.mask);
        check("out_err", bus.out_err, |x.mask);
        check("busy_done", bus.busy, 1);
        check("in_ready_done", bus.in_ready, 0);
        if (hold > 0) begin
            bus.out_ready = 0;
            for (int i = 0; i < hold; i++) begin
                bus.in_valid = 1;
                bus.in_bcd   = 16'($urandom);
                tick;
                check("hold_valid", bus.out_valid, 1);
                check("hold_ex3", bus.out_ex3, x.ex3);
                check("hold_mask", bus.out_err_mask, x.mask);
                check("hold_in_ready", bus.in_ready, 0);
            end
            bus.in_valid  = 0;
            bus.out_ready = 1;
        end
        tick;
        check("out_valid_pulse", bus.out_valid, 0);
        check("in_ready_after", bus.in_ready, 1);
    endtask

    initial begin
        bus.in_valid  = 0;
        bus.in_bcd    = '0;
        bus.out_ready = 1;
        tbl[0] = '{16'h1234, 16'h4567, 4'b0000};
        tbl[1] = '{16'h9050, 16'hC383, 4'b0000};
        tbl[2] = '{16'h0000, 16'h3333, 4'b0000};
        tbl[3] = '{16'h12A9, 16'h450C, 4'b0010};
        tbl[4] = '{16'hFFFF, 16'h0000, 4'b1111};
        tbl[5] = '{16'h9999, 16'hCCCC, 4'b0000};
        tbl[6] = '{16'hA0B0, 16'h0303, 4'b1010};
        repeat (3) tick;
        check("rst_in_ready", bus.in_ready, 1);
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_out_ex3", bus.out_ex3, 0);
        check("rst_out_err", bus.out_err, 0);
        check("rst_mask", bus.out_err_mask, 0);
        check("rst_busy", bus.busy, 0);
        rst = 0;
        tick;

        for (int i = 0; i < 7; i++) begin
            send(tbl[i].bcd, tbl[i].ex3, tbl[i].mask);
            recv(0);
        end
        for (int i = 0; i < 6; i++) begin
            logic [15:0] w;
            exp_t        e;
            w = 16'($urandom);
            e = model(w);
            send(w, e.ex3, e.mask);
            recv(0);
        end

        send(16'h1234, 16'h4567, 4'b0000);
        recv(5);

        bus.in_valid = 1;
        bus.in_bcd   = 16'h5678;
        tick;
        bus.in_valid = 0;
        tick;
        tick;
        check("mid_busy", bus.busy, 1);
        rst = 1;
        tick;
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_in_ready", bus.in_ready, 1);
        check("midrst_busy", bus.busy, 0);
        check("midrst_out_ex3", bus.out_ex3, 0);
        rst = 0;
        for (int i = 0; i < 6; i++) begin
            tick;
            check("midrst_no_output", bus.out_valid, 0);
        end
        send(16'h0987, 16'h3CBA, 4'b0000);
        recv(0);

`ifdef BCD_EX3_ERRCNT_EN
        rst = 1;
        tick;
        rst = 0;
        check("errcnt_rst", err_count, 0);
        for (int i = 0; i < 3; i++) begin
            send(16'h000B, 16'h3330, 4'b0001);
            recv(0);
        end
        check("errcnt_three", err_count, 3);
        for (int i = 0; i < 300; i++) begin
            send(16'hFFFF, 16'h0000, 4'b1111);
            recv(0);
        end
        check("errcnt_sat", err_count, 8'hFF);
        rst = 1;
        tick;
        rst = 0;
        check("errcnt_clear", err_count, 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
